// File: rtl/vram_port_arbiter_if.sv
// Bundle of the VGA, auxiliary and RAM port-b signals around the VRAM port arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus the RAM.
interface vram_port_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          vga_req;
  logic [AW-1:0] vga_addr;
  logic          vga_gnt;
  logic          vga_rvalid;
  logic [DW-1:0] vga_rdata;

  logic          aux_req;
  logic          aux_we;
  logic [AW-1:0] aux_addr;
  logic [DW-1:0] aux_wdata;
  logic          aux_gnt;
  logic          aux_rvalid;
  logic [DW-1:0] aux_rdata;

  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data;
  logic          ram_wren;
  logic [DW-1:0] ram_q;

  modport slave (
    input  vga_req, vga_addr,
    output vga_gnt, vga_rvalid, vga_rdata,
    input  aux_req, aux_we, aux_addr, aux_wdata,
    output aux_gnt, aux_rvalid, aux_rdata,
    output ram_address, ram_data, ram_wren,
    input  ram_q
  );

  modport master (
    output vga_req, vga_addr,
    input  vga_gnt, vga_rvalid, vga_rdata,
    output aux_req, aux_we, aux_addr, aux_wdata,
    input  aux_gnt, aux_rvalid, aux_rdata,
    input  ram_address, ram_data, ram_wren,
    output ram_q
  );
endinterface

// File: rtl/vram_port_arbiter.sv
// Shares frame RAM port b between the VGA scan-out reader and an auxiliary master,
// returning read data to its owner through a latency-matched tag pipeline.
module vram_port_arbiter #(
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int RD_LAT   = 2,
  parameter int MAX_WAIT = 8
) (
  input logic                clock,
  input logic                reset_n,
  vram_port_arbiter_if.slave bus
);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int NS = RD_LAT + 1;

  logic [WW-1:0] r_waitCnt;
  logic          w_force;
  logic          w_vgaGnt;
  logic          w_auxGnt;
  logic          w_vgaAcc;
  logic          w_auxAcc;
  logic          w_rdAcc;

  logic [NS-1:0] r_tagValid;
  logic [NS-1:0] r_tagOwner;

  logic [AW-1:0] r_ramAddress;
  logic [DW-1:0] r_ramData;
  logic          r_ramWren;
  logic          r_vgaRvalid;
  logic [DW-1:0] r_vgaRdata;
  logic          r_auxRvalid;
  logic [DW-1:0] r_auxRdata;

  // A starved aux request pre-empts VGA; otherwise VGA has priority.
  always_comb begin
    w_vgaGnt = 1'b0;
    w_auxGnt = 1'b0;
    w_force  = bus.aux_req && (r_waitCnt == WW'(MAX_WAIT));
    if (reset_n) begin
      if (w_force) begin
        w_auxGnt = 1'b1;
      end else if (bus.vga_req) begin
        w_vgaGnt = 1'b1;
      end else if (bus.aux_req) begin
        w_auxGnt = 1'b1;
      end
    end
  end

  assign w_vgaAcc = bus.vga_req & w_vgaGnt;
  assign w_auxAcc = bus.aux_req & w_auxGnt;
  assign w_rdAcc  = w_vgaAcc | (w_auxAcc & ~bus.aux_we);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_waitCnt <= '0;
    end else if (!bus.aux_req || w_auxAcc) begin
      r_waitCnt <= '0;
    end else if (r_waitCnt != WW'(MAX_WAIT)) begin
      r_waitCnt <= r_waitCnt + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ramAddress <= '0;
      r_ramData    <= '0;
      r_ramWren    <= 1'b0;
    end else begin
      r_ramWren <= w_auxAcc & bus.aux_we;
      if (w_vgaAcc) begin
        r_ramAddress <= bus.vga_addr;
      end else if (w_auxAcc) begin
        r_ramAddress <= bus.aux_addr;
        if (bus.aux_we) begin
          r_ramData <= bus.aux_wdata;
        end
      end
    end
  end

  // Owner bit: 0 = VGA, 1 = aux. Writes and idle cycles enter as invalid slots.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_tagValid <= '0;
      r_tagOwner <= '0;
    end else begin
      r_tagValid <= {r_tagValid[NS-2:0], w_rdAcc};
      r_tagOwner <= {r_tagOwner[NS-2:0], w_auxAcc};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_vgaRvalid <= 1'b0;
      r_vgaRdata  <= '0;
      r_auxRvalid <= 1'b0;
      r_auxRdata  <= '0;
    end else begin
      r_vgaRvalid <= r_tagValid[NS-1] & ~r_tagOwner[NS-1];
      r_auxRvalid <= r_tagValid[NS-1] &  r_tagOwner[NS-1];
      if (r_tagValid[NS-1]) begin
        if (r_tagOwner[NS-1]) begin
          r_auxRdata <= bus.ram_q;
        end else begin
          r_vgaRdata <= bus.ram_q;
        end
      end
    end
  end

  assign bus.vga_gnt     = w_vgaGnt;
  assign bus.aux_gnt     = w_auxGnt;
  assign bus.vga_rvalid  = r_vgaRvalid;
  assign bus.vga_rdata   = r_vgaRdata;
  assign bus.aux_rvalid  = r_auxRvalid;
  assign bus.aux_rdata   = r_auxRdata;
  assign bus.ram_address = r_ramAddress;
  assign bus.ram_data    = r_ramData;
  assign bus.ram_wren    = r_ramWren;
endmodule
